hc165_piso_tx: RTL and testbench

- Parallel-in, serial-out transmitter modelled on the 74HC165.
- Captures a WIDTH-bit word on a load request and shifts it out MSB first on one serial line with a complementary output.
- Signals completion so a downstream serial receiver chain (HC74 / shift-register capture stages) can frame the word.
- Sits between the lab's parallel data sources and the serial capture blocks, all on one clock.

---
 rtl/hc_pkg.sv | 15 +
 rtl/hc165_piso_tx_if.sv | 33 +++
 rtl/hc_bitcnt.sv | 36 +++
 rtl/hc165_piso_tx.sv | 94 +++++++++
 tb/tb_hc165_piso_tx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/hc_pkg.sv
// Shared definitions for the hc165/hc74 serial blocks.
// Holds the transfer state encoding and the state forced on reset. The sibling
// serial receiver uses the same package, so the encoding must stay stable.
package hc_pkg;

  // 2-bit transfer state; the fourth code is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } hc_state_t;

  localparam hc_state_t HC_RESET_STATE = ST_IDLE;

endpackage

// File: rtl/hc165_piso_tx_if.sv
// Bus between a parallel data source and the hc165 serial transmitter.
//   Load    : load request from the source
//   D       : parallel word, WIDTH bits
//   Ser_in  : cascade bit shifted into the LSB
//   Clk_inh : freezes shifting while high
//   Q_H     : serial data out (MSB first), Q_H_N its complement
//   Busy    : high while the word is being shifted
//   Done    : one-cycle pulse after the last bit
// master = data source side, slave = transmitter side.
interface hc165_piso_tx_if #(
  parameter int WIDTH = 8
);

  logic             Load;
  logic [WIDTH-1:0] D;
  logic             Ser_in;
  logic             Clk_inh;
  logic             Q_H;
  logic             Q_H_N;
  logic             Busy;
  logic             Done;

  modport master (
    output Load, D, Ser_in, Clk_inh,
    input  Q_H, Q_H_N, Busy, Done
  );

  modport slave (
    input  Load, D, Ser_in, Clk_inh,
    output Q_H, Q_H_N, Busy, Done
  );

endinterface

// File: rtl/hc_bitcnt.sv
// Loadable down-counter with zero flag, used to count bits left in a word.
//   Clk, Rst : clock, synchronous active-high reset (count -> 0)
//   ld       : load ld_val (takes priority over en)
//   ld_val   : value to load
//   en       : decrement request; ignored when the count is already zero
//   cnt      : current count
//   zero     : high when cnt == 0
module hc_bitcnt #(
  parameter int CNT_W = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_reg <= '0;
    end else if (ld) begin
      cnt_reg <= ld_val;
    end else if (en && (cnt_reg != '0)) begin
      // Saturate at zero so the count can never wrap.
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/hc165_piso_tx.sv
// Parallel-in, serial-out transmitter in the style of a 74HC165.
// A word is captured on an accepted Load and sent MSB first on Q_H; Ser_in
// fills the vacated LSBs so several stages can be cascaded. Done pulses for
// one cycle after the last bit so a downstream receiver can frame the word.
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : hc165_piso_tx_if slave (Load, D, Ser_in, Clk_inh in;
//              Q_H, Q_H_N, Busy, Done out)
// Every output comes straight from a register (or its inverse).
module hc165_piso_tx
  import hc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  hc165_piso_tx_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  hc_state_t        state_reg;
  logic [WIDTH-1:0] sr_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             load_ok;
  logic             shift_en;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  // A load is only honoured between words: in IDLE or in the DONE gap cycle.
  assign load_ok  = bus.Load && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign shift_en = (state_reg == ST_SHIFT) && !bus.Clk_inh;

  hc_bitcnt #(
    .CNT_W (CNT_W)
  ) u_bitcnt (
    .Clk    (Clk),
    .Rst    (Rst),
    .ld     (load_ok),
    .ld_val (LAST_IDX),
    .en     (shift_en && (cnt_val != '0)),
    .cnt    (cnt_val),
    .zero   (cnt_zero)
  );

  // Busy/Done are registered next to the state so they reflect it exactly.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= HC_RESET_STATE;
      sr_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (bus.Load) begin
            sr_reg    <= bus.D;
            state_reg <= ST_SHIFT;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end else begin
            // sr is left alone so Q_H keeps showing its last bit.
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (!bus.Clk_inh) begin
            sr_reg <= {sr_reg[WIDTH-2:0], bus.Ser_in};
            if (cnt_zero) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Q_H   = sr_reg[WIDTH-1];
  assign bus.Q_H_N = ~sr_reg[WIDTH-1];
  assign bus.Busy  = busy_reg;
  assign bus.Done  = done_reg;

endmodule

// File: tb/tb_hc165_piso_tx.sv
module tb_hc165_piso_tx;

  logic        clk;
  logic        rst;
  logic        load;
  logic [31:0] d;
  logic        ser;
  logic        inh;
  int          sel;   // 0: WIDTH=2, 1: WIDTH=8, 2: WIDTH=32

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hc165_piso_tx_if #(.WIDTH(2))  if2 ();
  hc165_piso_tx_if #(.WIDTH(8))  if8 ();
  hc165_piso_tx_if #(.WIDTH(32)) if32 ();

  assign if2.Load     = load && (sel == 0);
  assign if2.D        = d[1:0];
  assign if2.Ser_in   = ser;
  assign if2.Clk_inh  = inh;
  assign if8.Load     = load && (sel == 1);
  assign if8.D        = d[7:0];
  assign if8.Ser_in   = ser;
  assign if8.Clk_inh  = inh;
  assign if32.Load    = load && (sel == 2);
  assign if32.D       = d;
  assign if32.Ser_in  = ser;
  assign if32.Clk_inh = inh;

  hc165_piso_tx #(.WIDTH(2))  u_dut2  (.Clk(clk), .Rst(rst), .bus(if2));
  hc165_piso_tx #(.WIDTH(8))  u_dut8  (.Clk(clk), .Rst(rst), .bus(if8));
  hc165_piso_tx #(.WIDTH(32)) u_dut32 (.Clk(clk), .Rst(rst), .bus(if32));

  logic qh_o, qhn_o, busy_o, done_o;
  always_comb begin
    qh_o = if8.Q_H; qhn_o = if8.Q_H_N; busy_o = if8.Busy; done_o = if8.Done;
    case (sel)
      0: begin qh_o = if2.Q_H;  qhn_o = if2.Q_H_N;  busy_o = if2.Busy;  done_o = if2.Done;  end
      2: begin qh_o = if32.Q_H; qhn_o = if32.Q_H_N; busy_o = if32.Busy; done_o = if32.Done; end
      default: ;
    endcase
  end

  // Reference model: a transfer is "word bits first, then the Ser_in bits
  // received so far", indexed by how many non-inhibited shifts have happened.
  int          w;
  bit          m_busy, m_done;
  int          m_n;
  logic [31:0] m_word;
  bit          ser_q[$];
  logic        m_q;

  // Per-transaction bookkeeping driven from the stimulus side.
  int          cyc;
  int          done_at;
  logic [31:0] stream;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic expected_bit(input int n);
    if (n < w) return m_word[w-1-n];
    return ser_q[n-w];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_done = 0; m_q = 1'b0;
    end else if (m_busy) begin
      if (!inh) begin
        ser_q.push_back(ser);
        m_n++;
        m_q = expected_bit(m_n);
        if (m_n == w) begin m_busy = 0; m_done = 1; end
      end
    end else begin
      m_done = 0;
      if (load) begin
        m_busy = 1; m_n = 0; m_word = d; ser_q.delete();
        m_q = expected_bit(0);
      end
    end
    #1;
    cyc++;
    if (done_o === 1'b1 && done_at < 0) done_at = cyc;
    if (cyc >= 1 && cyc <= w) stream = {stream[30:0], qh_o};
    check("q_h",   {31'd0, qh_o},   {31'd0, m_q});
    check("q_h_n", {31'd0, qhn_o},  {31'd0, ~m_q});
    check("busy",  {31'd0, busy_o}, {31'd0, m_busy});
    check("done",  {31'd0, done_o}, {31'd0, m_done});
  endtask

  task automatic load_word(input logic [31:0] dv);
    $display("[TB] load W=%0d D=%h ser=%0b", w, dv, ser);
    d = dv; load = 1'b1; cyc = 0; done_at = -1; stream = '0;
    tick();
    load = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] wmask(input int width);
    logic [31:0] one;
    if (width >= 32) return 32'hFFFF_FFFF;
    one = 32'd1;
    return (one << width) - 32'd1;
  endfunction

  task automatic select(input int s, input int width);
    sel = s; w = width;
    rst = 1'b1; load = 1'b0; inh = 1'b0; ser = 1'b0;
    ticks(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; d = '0; ser = 1'b0; inh = 1'b0;
    sel = 1; w = 8; cyc = 0; done_at = -1; stream = '0;
    m_busy = 0; m_done = 0; m_n = 0; m_word = '0; m_q = 1'b0;

    // Reset state, WIDTH=8
    select(1, 8);
    check("reset_q_h_n", {31'd0, qhn_o}, 32'd1);

    // Basic A5
    load_word(32'hA5);
    ticks(11);
    check("a5_done_cycle", done_at, 32'd9);
    check("a5_stream", stream, 32'hA5);

    // Inhibit during cycles 3..5
    load_word(32'hF0);
    for (int c = 1; c <= 13; c++) begin
      inh = (c >= 3 && c <= 5);
      tick();
    end
    inh = 1'b0;
    check("inh_done_cycle", done_at, 32'd12);

    // Back-to-back with an ignored mid-shift load
    load_word(32'h81);
    ticks(2);
    d = 32'hFF; load = 1'b1; tick(); load = 1'b0;
    ticks(5);
    check("b2b_first_stream", stream, 32'h81);
    check("b2b_in_done", {31'd0, done_o}, 32'd1);
    load_word(32'h7E);
    ticks(11);
    check("b2b_done_cycle", done_at, 32'd9);
    check("b2b_stream", stream, 32'h7E);

    // Cascade: Ser_in=1 appears after the word, then holds in IDLE
    ser = 1'b1;
    load_word(32'h00);
    ticks(8);
    ser = 1'b0;
    ticks(4);
    check("casc_stream", stream, 32'h00);
    check("casc_done_cycle", done_at, 32'd9);
    check("casc_hold", {31'd0, qh_o}, 32'd1);

    // Reset mid-word
    load_word(32'hFF);
    ticks(3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_q_h", {31'd0, qh_o}, 32'd0);
    ticks(10);
    check("rst_no_done", done_at, 32'hFFFF_FFFF);
    load_word(32'h3C);
    ticks(10);
    check("rst_reload_stream", stream, 32'h3C);

    // Width sweep
    select(0, 2);
    load_word(32'h2);
    ticks(4);
    check("w2_done_cycle", done_at, 32'd3);
    check("w2_stream", stream, 32'h2);

    select(2, 32);
    load_word(32'hDEADBEEF);
    ticks(34);
    check("w32_done_cycle", done_at, 32'd33);
    check("w32_stream", stream, 32'hDEADBEEF);

    // Randomized traffic on every width, including an untouched-word check
    for (int s = 0; s < 3; s++) begin
      int widths[3] = '{2, 8, 32};
      logic [31:0] rw;
      select(s, widths[s]);
      for (int k = 0; k < 4; k++) begin
        rw = $urandom;
        load_word(rw);
        ticks(widths[s] + 2);
        check("rand_stream", stream, rw & wmask(widths[s]));
      end
      for (int i = 0; i < 400; i++) begin
        load = ($urandom_range(0, 3) == 0);
        d    = $urandom;
        ser  = 1'($urandom_range(0, 1));
        inh  = ($urandom_range(0, 4) == 0);
        rst  = ($urandom_range(0, 99) == 0);
        tick();
      end
      rst = 1'b0; load = 1'b0; inh = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
